// File: rtl/csi2_px_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csi2_px_pkg
// Description : Shared types and constants for the CSI-2 pixel unpacker.
//               Pixel-format enum, packed input word width and output
//               lane width.
// Revision    : 1.0 - initial release
// ============================================================================
package csi2_px_pkg;

  // Pixel format carried by mode_i; value 3 is reserved and never stored.
  typedef enum logic [1:0] {
    RAW8  = 2'd0,
    RAW10 = 2'd1,
    RAW12 = 2'd2
  } px_mode_e;

  localparam logic [1:0] MODE_RESERVED = 2'd3;

  // Packed input word: four MSB bytes plus up to 16 LSB bits.
  localparam int IN_W   = 48;
  // One unpacked pixel, right-aligned.
  localparam int LANE_W = 16;

endpackage
`default_nettype wire

// File: rtl/axi4_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4_stream_if
// Description : Minimal AXI4-Stream bundle with master/slave modports.
// Ports       : tvalid/tready handshake, tdata (DATA_W), tkeep/tstrb
//               (DATA_W/8), tlast, tuser (1 bit).
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4_stream_if #(
  parameter int DATA_W = 48
) ();

  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tkeep;
  logic [DATA_W/8-1:0]   tstrb;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tuser,
    output tready
  );

endinterface
`default_nettype wire

// File: rtl/csi2_px_lane_extract.sv
`default_nettype none
// ============================================================================
// Module      : csi2_px_lane_extract
// Description : Purely combinational extraction of one pixel from a packed
//               4-pixel word into a right-aligned 16-bit lane.
// Ports       : word_i  - packed word (MSB bytes in [31:0], LSBs in [47:32])
//               mode_i  - pixel format
//               idx_i   - pixel index 0..3 within the word
//               lane_o  - unpacked pixel, upper bits zero
// Revision    : 1.0 - initial release
// ============================================================================
module csi2_px_lane_extract
  import csi2_px_pkg::*;
(
  input  logic [IN_W-1:0]   word_i,
  input  px_mode_e          mode_i,
  input  logic [1:0]        idx_i,
  output logic [LANE_W-1:0] lane_o
);

  logic [7:0] msb_byte;
  logic [1:0] lsb_raw10;
  logic [3:0] lsb_raw12;

  // Bit offsets are built as 6-bit values so they span the full 48-bit word.
  always_comb begin
    msb_byte  = word_i[{1'b0, idx_i, 3'b000} +: 8];
    lsb_raw10 = word_i[6'd32 + {3'b000, idx_i, 1'b0} +: 2];
    lsb_raw12 = word_i[6'd32 + {2'b00, idx_i, 2'b00} +: 4];
    case (mode_i)
      RAW8:    lane_o = {8'h00, msb_byte};
      RAW10:   lane_o = {6'h00, msb_byte, lsb_raw10};
      RAW12:   lane_o = {4'h0, msb_byte, lsb_raw12};
      default: lane_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/csi2_px_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : csi2_px_unpacker
// Description : Unpacks 48-bit CSI-2 style words (4 pixels, RAW8/10/12) into
//               beats of PX_PER_BEAT right-aligned 16-bit pixels. One word is
//               held in a register; all outputs come from that register.
// Ports       : clk_i, rst_i (async, active-high)
//               frame_start_i - frame-start pulse, latches mode_i, marks tuser
//               mode_i        - 0 RAW8, 1 RAW10, 2 RAW12, 3 reserved (ignored)
//               pkt_i         - packed input stream (48-bit tdata)
//               pkt_o         - unpacked output stream (16*PX_PER_BEAT tdata)
//               line_len_o    - pixel count of the last completed line
// Revision    : 1.0 - initial release
// ============================================================================
module csi2_px_unpacker #(
  parameter int PX_PER_BEAT = 1,
  parameter int LINE_CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  frame_start_i,
  input  logic [1:0]            mode_i,
  axi4_stream_if.slave          pkt_i,
  axi4_stream_if.master         pkt_o,
  output logic [LINE_CNT_W-1:0] line_len_o
);

  import csi2_px_pkg::*;

  localparam int                    BEATS     = 4 / PX_PER_BEAT;
  localparam logic [1:0]            LAST_BEAT = 2'(BEATS - 1);
  // Two-bit step is exact for 1 and 2; for 4 the beat counter never leaves 0.
  localparam logic [1:0]            PX_STEP   = 2'(PX_PER_BEAT);
  localparam logic [LINE_CNT_W-1:0] PX_INC    = LINE_CNT_W'(PX_PER_BEAT);

  logic                  valid_q, valid_d;
  logic [1:0]            beat_cnt_q, beat_cnt_d;
  logic [IN_W-1:0]       word_q, word_d;
  px_mode_e              word_mode_q, word_mode_d;
  logic                  last_q, last_d;
  logic                  mark_q, mark_d;
  logic                  start_flag_q, start_flag_d;
  px_mode_e              mode_q, mode_d;
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [LINE_CNT_W-1:0] line_len_q, line_len_d;

  logic                  last_beat, in_ready, in_hs, out_hs, out_last, out_user;
  logic                  line_cnt_carry;
  logic [LINE_CNT_W-1:0] line_cnt_sum, line_cnt_sat;
  logic [LANE_W*PX_PER_BEAT-1:0] lanes;
  logic                  unused_in_sideband;

  assign last_beat = (beat_cnt_q == LAST_BEAT);
  assign in_ready  = !valid_q || (pkt_o.tready && last_beat);
  assign in_hs     = pkt_i.tvalid && in_ready;
  assign out_hs    = valid_q && pkt_o.tready;
  assign out_last  = valid_q && last_q && last_beat;
  assign out_user  = valid_q && mark_q && (beat_cnt_q == 2'd0);

  assign {line_cnt_carry, line_cnt_sum} = {1'b0, line_cnt_q} + {1'b0, PX_INC};
  assign line_cnt_sat = line_cnt_carry ? '1 : line_cnt_sum;

  assign unused_in_sideband = ^{pkt_i.tkeep, pkt_i.tstrb, pkt_i.tuser};

  // Lane j of beat b carries pixel b*PX_PER_BEAT + j.
  for (genvar j = 0; j < PX_PER_BEAT; j++) begin : g_lane
    logic [1:0] lane_idx;
    assign lane_idx = beat_cnt_q * PX_STEP + 2'(j);
    csi2_px_lane_extract u_lane_extract (
      .word_i (word_q),
      .mode_i (word_mode_q),
      .idx_i  (lane_idx),
      .lane_o (lanes[LANE_W*j +: LANE_W])
    );
  end

  always_comb begin
    valid_d      = valid_q;
    beat_cnt_d   = beat_cnt_q;
    word_d       = word_q;
    word_mode_d  = word_mode_q;
    last_d       = last_q;
    mark_d       = mark_q;
    mode_d       = mode_q;
    line_cnt_d   = line_cnt_q;
    line_len_d   = line_len_q;

    if (frame_start_i && (mode_i != MODE_RESERVED)) begin
      mode_d = px_mode_e'(mode_i);
    end
    // The start flag survives until a word has been marked by it.
    start_flag_d = (start_flag_q || frame_start_i) && !in_hs;

    if (out_hs) begin
      beat_cnt_d = last_beat ? 2'd0 : beat_cnt_q + 2'd1;
      if (last_beat) begin
        valid_d = 1'b0;
      end
      if (out_last) begin
        line_len_d = line_cnt_sat;
        line_cnt_d = '0;
      end else begin
        line_cnt_d = line_cnt_sat;
      end
    end

    // A word accepted in the frame-start cycle already uses the new mode;
    // the word in flight keeps its own captured mode.
    if (in_hs) begin
      valid_d     = 1'b1;
      word_d      = pkt_i.tdata;
      word_mode_d = mode_d;
      last_d      = pkt_i.tlast;
      mark_d      = start_flag_q || frame_start_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      beat_cnt_q   <= 2'd0;
      word_q       <= '0;
      word_mode_q  <= RAW10;
      last_q       <= 1'b0;
      mark_q       <= 1'b0;
      start_flag_q <= 1'b0;
      mode_q       <= RAW10;
      line_cnt_q   <= '0;
      line_len_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      beat_cnt_q   <= beat_cnt_d;
      word_q       <= word_d;
      word_mode_q  <= word_mode_d;
      last_q       <= last_d;
      mark_q       <= mark_d;
      start_flag_q <= start_flag_d;
      mode_q       <= mode_d;
      line_cnt_q   <= line_cnt_d;
      line_len_q   <= line_len_d;
    end
  end

  assign pkt_i.tready = in_ready;
  assign pkt_o.tvalid = valid_q;
  assign pkt_o.tdata  = lanes;
  assign pkt_o.tlast  = out_last;
  assign pkt_o.tuser  = out_user;
  assign pkt_o.tkeep  = '1;
  assign pkt_o.tstrb  = '1;
  assign line_len_o   = line_len_q;

endmodule
`default_nettype wire

// File: tb/tb_csi2_px_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_csi2_px_unpacker
// Description : Scoreboard bench. Three unpackers (1, 2 and 4 pixels per
//               beat) share clock, reset, frame_start_i and mode_i; one is
//               exercised at a time. Stimulus pushes expected beats into a
//               queue, a monitor pops and compares on every output handshake
//               and checks that outputs hold during stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csi2_px_unpacker;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       frame_start_i = 1'b0;
  logic [1:0] mode_i = 2'd0;

  always #5 clk_i = ~clk_i;

  logic [2:0]        in_valid  = '0;
  logic [2:0][47:0]  in_data   = '0;
  logic [2:0]        in_last   = '0;
  logic [2:0]        in_ready;
  logic [2:0]        out_ready = '1;
  logic [2:0]        out_valid;
  logic [2:0][63:0]  out_data;
  logic [2:0]        out_last;
  logic [2:0]        out_user;
  logic [2:0]        keep_ok;
  logic [2:0][15:0]  line_len;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int PX = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    axi4_stream_if #(.DATA_W(48))      in_if ();
    axi4_stream_if #(.DATA_W(16 * PX)) out_if ();

    assign in_if.tvalid  = in_valid[g];
    assign in_if.tdata   = in_data[g];
    assign in_if.tlast   = in_last[g];
    assign in_if.tuser   = 1'b0;
    assign in_if.tkeep   = '1;
    assign in_if.tstrb   = '1;
    assign in_ready[g]   = in_if.tready;
    assign out_if.tready = out_ready[g];
    assign out_valid[g]  = out_if.tvalid;
    assign out_data[g]   = 64'(out_if.tdata);
    assign out_last[g]   = out_if.tlast;
    assign out_user[g]   = out_if.tuser;
    assign keep_ok[g]    = (&out_if.tkeep) & (&out_if.tstrb);

    csi2_px_unpacker #(.PX_PER_BEAT(PX), .LINE_CNT_W(16)) u_dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .frame_start_i (frame_start_i),
      .mode_i        (mode_i),
      .pkt_i         (in_if),
      .pkt_o         (out_if),
      .line_len_o    (line_len[g])
    );
  end

  typedef struct packed {
    logic [1:0]  inst;
    logic [63:0] data;
    logic        last;
    logic        user;
  } exp_t;

  typedef struct packed {
    logic [47:0] data;
    logic        last;
  } stim_t;

  exp_t  sb[$];
  stim_t stim_q[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    hs_cnt[3];
  int    first_hs[3];
  int    last_hs[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference pixel former, straight from the word layout.
  function automatic logic [15:0] pix(input logic [47:0] w, input int mode, input int k);
    logic [7:0] m;
    m = w[8*k +: 8];
    case (mode)
      0:       return {8'h00, m};
      1:       return {6'h00, m, w[32+2*k +: 2]};
      default: return {4'h0, m, w[32+4*k +: 4]};
    endcase
  endfunction

  task automatic push_model(input int g, input int mode, input logic [47:0] w,
                            input logic last, input logic user);
    int px;
    px = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    stim_q.push_back('{w, last});
    for (int b = 0; b < 4 / px; b++) begin
      logic [63:0] d;
      d = '0;
      for (int j = 0; j < px; j++) d[16*j +: 16] = pix(w, mode, b * px + j);
      sb.push_back('{2'(g), d, last && (b == 4 / px - 1), user && (b == 0)});
    end
  endtask

  // Drains stim_q into instance g; returns cycles spent waiting for tready.
  task automatic drive(input int g, output int stalls);
    stalls = 0;
    while (stim_q.size() != 0) begin
      stim_t s;
      int t;
      s = stim_q.pop_front();
      t = 0;
      in_valid[g] = 1'b1;
      in_data[g]  = s.data;
      in_last[g]  = s.last;
      @(negedge clk_i);
      while (!in_ready[g] && t < 200) begin
        stalls++;
        t++;
        @(negedge clk_i);
      end
      if (!in_ready[g]) begin
        total++;
        bad++;
        $display("FAIL drive inst%0d: pkt_i.tready still 0 after %0d cycles, want 1", g, t);
        stim_q.delete();
      end
      @(posedge clk_i);
      #1;
    end
    in_valid[g] = 1'b0;
    in_last[g]  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(posedge clk_i);
      t++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d beats outstanding after %0d cycles, want 0", sb.size(), t);
      sb.delete();
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_all();
    rst_i     = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    out_ready = '1;
    sb.delete();
    stim_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    frame_start_i = 1'b1;
    mode_i        = m;
    @(posedge clk_i);
    #1;
    frame_start_i = 1'b0;
  endtask

  // Monitor: pops on every output handshake, checks holds during stalls.
  initial begin : monitor
    logic [2:0]       pv;
    logic [2:0]       pr;
    logic [2:0][63:0] pd;
    logic [2:0]       pl;
    logic [2:0]       pu;
    exp_t             e;
    pv = '0; pr = '0; pd = '0; pl = '0; pu = '0;
    forever begin
      @(negedge clk_i);
      cyc++;
      for (int g = 0; g < 3; g++) begin
        if (rst_i) begin
          pv[g] = 1'b0;
          hs_cnt[g] = 0;
          continue;
        end
        if (pv[g] && !pr[g]) begin
          check($sformatf("hold data inst%0d", g), out_data[g], pd[g]);
          check($sformatf("hold ctrl inst%0d", g),
                64'({out_valid[g], out_last[g], out_user[g]}), 64'({1'b1, pl[g], pu[g]}));
        end
        if (out_valid[g] && out_ready[g]) begin
          hs_cnt[g]++;
          if (hs_cnt[g] == 1) first_hs[g] = cyc;
          last_hs[g] = cyc;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected beat inst%0d: got data=%0h, want no beat", g, out_data[g]);
          end else begin
            e = sb.pop_front();
            check($sformatf("beat inst%0d", g), 64'(g), 64'(e.inst));
            check($sformatf("beat data inst%0d", g), out_data[g], e.data);
            check($sformatf("beat last/user inst%0d", g),
                  64'({out_last[g], out_user[g]}), 64'({e.last, e.user}));
          end
        end
        pv[g] = out_valid[g];
        pr[g] = out_ready[g];
        pd[g] = out_data[g];
        pl[g] = out_last[g];
        pu[g] = out_user[g];
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int          stalls;
    logic [3:0]  rp;
    logic        done_d;
    logic [47:0] w;

    // ---- reset state ----
    reset_all();
    for (int g = 0; g < 3; g++) begin
      check($sformatf("reset tvalid inst%0d", g), 64'(out_valid[g]), 64'd0);
      check($sformatf("reset tdata inst%0d", g), out_data[g], 64'd0);
      check($sformatf("reset tlast/tuser inst%0d", g), 64'({out_last[g], out_user[g]}), 64'd0);
      check($sformatf("reset line_len inst%0d", g), 64'(line_len[g]), 64'd0);
      check($sformatf("reset in tready inst%0d", g), 64'(in_ready[g]), 64'd1);
      check($sformatf("tkeep/tstrb ones inst%0d", g), 64'(keep_ok[g]), 64'd1);
    end

    // ---- RAW10, 1 px/beat: 0xAB supplies LSBs 3,2,2,2 for pixels 0..3 ----
    set_mode(2'd1);
    stim_q.push_back('{48'h00AB_44332211, 1'b0});
    sb.push_back('{2'd0, 64'h0047, 1'b0, 1'b1});
    sb.push_back('{2'd0, 64'h008A, 1'b0, 1'b0});
    sb.push_back('{2'd0, 64'h00CE, 1'b0, 1'b0});
    sb.push_back('{2'd0, 64'h0112, 1'b0, 1'b0});
    drive(0, stalls);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      rp[i] = in_ready[0];
    end
    check("in tready low 3 cycles px1", 64'(rp), 64'h8);
    drain();

    // ---- RAW12, 2 px/beat, word with tlast ----
    reset_all();
    set_mode(2'd2);
    stim_q.push_back('{48'h4321_DDCCBBAA, 1'b1});
    sb.push_back('{2'd1, 64'h0BB2_0AA1, 1'b0, 1'b1});
    sb.push_back('{2'd1, 64'h0DD4_0CC3, 1'b1, 1'b0});
    drive(1, stalls);
    drain();
    check("line_len raw12 px2", 64'(line_len[1]), 64'd4);

    // ---- RAW8, 4 px/beat, 8 back-to-back words ----
    reset_all();
    set_mode(2'd0);
    for (int i = 0; i < 8; i++) begin
      w = {16'hFFFF, 8'(8'h10 * i + 4), 8'(8'h10 * i + 3), 8'(8'h10 * i + 2), 8'(8'h10 * i + 1)};
      push_model(2, 0, w, 1'b0, i == 0);
    end
    drive(2, stalls);
    check("in tready constant px4", 64'(stalls), 64'd0);
    drain();
    check("beat count px4", 64'(hs_cnt[2]), 64'd8);
    check("consecutive beats px4", 64'(last_hs[2] - first_hs[2]), 64'd7);

    // ---- random output stalls, 100 words, RAW10, 2 px/beat ----
    reset_all();
    set_mode(2'd1);
    for (int i = 0; i < 100; i++) begin
      w = {16'($urandom), 32'($urandom)};
      push_model(1, 1, w, (i % 10) == 9, i == 0);
    end
    done_d = 1'b0;
    fork
      begin
        drive(1, stalls);
        drain();
        done_d = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!done_d && k < 20000) begin
          @(posedge clk_i);
          #1;
          out_ready[1] = 1'($urandom_range(0, 1));
          k++;
        end
      end
    join
    out_ready = '1;
    check("line_len random px2", 64'(line_len[1]), 64'd40);

    // ---- frame start together with the first handshake; reserved mode ----
    reset_all();
    push_model(0, 1, 48'h005B_0A0B0C0D, 1'b0, 1'b1);
    void'(stim_q.pop_front());
    frame_start_i = 1'b1;
    mode_i        = 2'd1;
    in_valid[0]   = 1'b1;
    in_data[0]    = 48'h005B_0A0B0C0D;
    @(posedge clk_i);
    #1;
    frame_start_i = 1'b0;
    in_valid[0]   = 1'b0;
    push_model(0, 1, 48'h00C6_1F2E3D4C, 1'b0, 1'b0);
    drive(0, stalls);
    set_mode(2'd3);
    push_model(0, 1, 48'h00E4_A1B2C3D4, 1'b0, 1'b1);
    drive(0, stalls);
    drain();

    // ---- line of 10 words, 1 px/beat, then reset mid-word ----
    reset_all();
    set_mode(2'd0);
    for (int i = 0; i < 10; i++) begin
      w = {16'h0, 8'(i + 8'h40), 8'(i + 8'h30), 8'(i + 8'h20), 8'(i + 8'h10)};
      push_model(0, 0, w, i == 9, i == 0);
    end
    drive(0, stalls);
    drain();
    check("line_len 10 words px1", 64'(line_len[0]), 64'd40);
    push_model(0, 0, 48'h0000_DEADBEEF, 1'b0, 1'b0);
    drive(0, stalls);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    sb.delete();
    #1;
    check("async reset tvalid", 64'(out_valid[0]), 64'd0);
    @(posedge clk_i);
    #1;
    check("reset mid-word tvalid", 64'(out_valid[0]), 64'd0);
    check("reset mid-word line_len", 64'(line_len[0]), 64'd0);
    rst_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;
    check("no partial beats after reset", 64'(out_valid[0]), 64'd0);
    check("in tready after reset", 64'(in_ready[0]), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
